regfile_param: RTL and testbench

//  - Parametrised, clocked register file; successor to the single-cycle combinational register block.
//  - Synchronous write port; NUM_RD asynchronous read ports, each with its own size/extension mode.
//  - Built-in clear sequencer zeroes the array after reset or on request; register 0 reads as zero.
//  - Sits between decode (read addresses) and writeback (write port) of the datapath.

---
 rtl/regfile_pkg.sv | 16 +
 rtl/regfile_extend.sv | 22 ++
 rtl/regfile_param.sv | 133 +++++++++++++
 tb/tb_regfile_param.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared encodings for the parametrised register file: extension sizes and sequencer states.
package regfile_pkg;

    typedef enum logic [1:0] {
        SZ_WORD   = 2'b00,
        SZ_BYTE_S = 2'b01,
        SZ_BYTE_U = 2'b10,
        SZ_HALF_S = 2'b11
    } size_e;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

endpackage

// File: rtl/regfile_extend.sv
// Width adjustment of a register value: word pass-through, byte sign/zero extend, half sign extend.
module regfile_extend
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [DATA_W-1:0] data_in,
    input  logic [1:0]        size,
    output logic [DATA_W-1:0] data_out
);

    always_comb begin
        data_out = data_in;
        case (size)
            SZ_BYTE_S: data_out = {{(DATA_W-8){data_in[7]}}, data_in[7:0]};
            SZ_BYTE_U: data_out = {{(DATA_W-8){1'b0}}, data_in[7:0]};
            SZ_HALF_S: data_out = {{(DATA_W-16){data_in[15]}}, data_in[15:0]};
            default:   data_out = data_in;
        endcase
    end

endmodule

// File: rtl/regfile_param.sv
// Clocked register file with NUM_RD extending read ports and a zeroing sequencer.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to matching read ports.
module regfile_param
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned NUM_RD = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear_req,
    output logic                       ready,
    input  logic                       write_en,
    input  logic [ADDR_W-1:0]          write_addr,
    input  logic [DATA_W-1:0]          write_data,
    input  logic [1:0]                 write_size,
    output logic                       write_drop,
    input  logic [NUM_RD*ADDR_W-1:0]   read_addr,
    input  logic [NUM_RD*2-1:0]        read_size,
    output logic [NUM_RD*DATA_W-1:0]   read_data
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    state_e              state_q;
    state_e              state_d;
    logic [ADDR_W-1:0]   clr_cnt_q;
    logic [ADDR_W-1:0]   clr_cnt_d;
    logic                ready_d;
    logic                write_drop_d;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W-1:0]   write_ext;
    logic [DATA_W-1:0]   mem [DEPTH];

    regfile_extend #(.DATA_W(DATA_W)) u_wr_ext (
        .data_in  (write_data),
        .size     (write_size),
        .data_out (write_ext)
    );

    // Sequencer next state and the single array write port (clear has priority).
    always_comb begin
        state_d      = state_q;
        clr_cnt_d    = clr_cnt_q;
        ready_d      = ready;
        write_drop_d = 1'b0;
        mem_we       = 1'b0;
        mem_waddr    = write_addr;
        mem_wdata    = write_ext;
        case (state_q)
            ST_CLEAR: begin
                mem_we       = 1'b1;
                mem_waddr    = clr_cnt_q;
                mem_wdata    = '0;
                write_drop_d = write_en;
                if (clr_cnt_q == ADDR_W'(DEPTH - 1)) begin
                    state_d   = ST_READY;
                    ready_d   = 1'b1;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + ADDR_W'(1);
                end
            end
            ST_READY: begin
                if (clear_req) begin
                    state_d   = ST_CLEAR;
                    clr_cnt_d = '0;
                    ready_d   = 1'b0;
                end else if (write_en && (write_addr != '0)) begin
                    mem_we = 1'b1;
                end
            end
            default: begin
                state_d   = ST_CLEAR;
                clr_cnt_d = '0;
                ready_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_CLEAR;
            clr_cnt_q  <= '0;
            ready      <= 1'b0;
            write_drop <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            ready      <= ready_d;
            write_drop <= write_drop_d;
        end
    end

    // Storage array carries no reset; the sequencer defines its contents.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] raw;
        logic [DATA_W-1:0] ext;

        assign addr = read_addr[p*ADDR_W +: ADDR_W];

        always_comb begin
            raw = mem[addr];
`ifdef REGFILE_BYPASS_EN
            if (ready && write_en && (write_addr != '0) && (write_addr == addr)) begin
                raw = write_ext;
            end
`endif
            if (addr == '0) begin
                raw = '0;
            end
        end

        regfile_extend #(.DATA_W(DATA_W)) u_rd_ext (
            .data_in  (raw),
            .size     (read_size[p*2 +: 2]),
            .data_out (ext)
        );

        assign read_data[p*DATA_W +: DATA_W] = ready ? ext : '0;
    end

endmodule

// File: tb/tb_regfile_param.sv
// Scoreboard bench for regfile_param: stimulus pushes model expectations, a negedge monitor checks them.
module tb_regfile_param;

    logic        clk;
    logic        reset;
    logic        clear_req;
    logic        ready;
    logic        write_en;
    logic [4:0]  write_addr;
    logic [31:0] write_data;
    logic [1:0]  write_size;
    logic        write_drop;
    logic [9:0]  read_addr;
    logic [3:0]  read_size;
    logic [63:0] read_data;

    regfile_param #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .clear_req  (clear_req),
        .ready      (ready),
        .write_en   (write_en),
        .write_addr (write_addr),
        .write_data (write_data),
        .write_size (write_size),
        .write_drop (write_drop),
        .read_addr  (read_addr),
        .read_size  (read_size),
        .read_data  (read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rdy;
        logic        drop;
        logic [63:0] rd;
        bit          hk0;
        logic [31:0] k0;
        bit          hk1;
        logic [31:0] k1;
        int          tag;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_pass   = 0;
    int          tag_cnt  = 0;

    // Reference model: contents, remaining clear cycles, pending drop pulse.
    logic [31:0] m_mem [32];
    int          m_left;
    logic        m_drop;

    function automatic logic [31:0] m_ext(input logic [31:0] d, input logic [1:0] s);
        longint v;
        case (s)
            2'b01: begin v = longint'(d & 32'hFF);   if (v >= 128)   v = v - 256;   end
            2'b10: v = longint'(d & 32'hFF);
            2'b11: begin v = longint'(d & 32'hFFFF); if (v >= 32768) v = v - 65536; end
            default: v = longint'(d);
        endcase
        return 32'(v);
    endfunction

    function automatic logic [31:0] exp_rd(input int p);
        logic [4:0]  a;
        logic [1:0]  s;
        logic [31:0] raw;
        a = read_addr[p*5 +: 5];
        s = read_size[p*2 +: 2];
        if (reset || m_left != 0) return 32'h0;
        raw = (a == 5'd0) ? 32'h0 : m_mem[a];
`ifdef REGFILE_BYPASS_EN
        if (write_en && write_addr != 5'd0 && a == write_addr) raw = m_ext(write_data, write_size);
`endif
        return m_ext(raw, s);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want, input int tag);
        n_checks++;
        if (act === want) n_pass++;
        else $display("FAIL %s tag=%0d got=%h want=%h", nm, tag, act, want);
    endtask

    // Issue one cycle: record expectation for the current inputs, then advance the model at the edge.
    task automatic step(input bit hk0, input logic [31:0] k0, input bit hk1, input logic [31:0] k1);
        exp_t e;
        e.rdy  = !reset && (m_left == 0);
        e.drop = reset ? 1'b0 : m_drop;
        e.rd   = {exp_rd(1), exp_rd(0)};
        e.hk0  = hk0; e.k0 = k0; e.hk1 = hk1; e.k1 = k1;
        e.tag  = tag_cnt++;
        sb.push_back(e);
        @(posedge clk);
        if (reset) begin
            m_left = 32; m_drop = 1'b0;
            for (int i = 0; i < 32; i++) m_mem[i] = 32'h0;
        end else begin
            m_drop = write_en && (m_left != 0);
            if (m_left != 0) m_left--;
            else if (clear_req) begin
                m_left = 32;
                for (int i = 0; i < 32; i++) m_mem[i] = 32'h0;
            end else if (write_en && write_addr != 5'd0)
                m_mem[write_addr] = m_ext(write_data, write_size);
        end
        #1;
    endtask

    task automatic idle_step();
        step(1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [1:0] s);
        write_en = 1'b1; write_addr = a; write_data = d; write_size = s;
        idle_step();
        write_en = 1'b0;
    endtask

    task automatic rd0(input logic [4:0] a, input logic [1:0] s, input logic [31:0] k);
        read_addr[4:0] = a; read_size[1:0] = s;
        step(1'b1, k, 1'b0, 32'h0);
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            chk("ready", 32'(ready), 32'(mon_e.rdy), mon_e.tag);
            chk("write_drop", 32'(write_drop), 32'(mon_e.drop), mon_e.tag);
            chk("read_data0", read_data[31:0], mon_e.rd[31:0], mon_e.tag);
            chk("read_data1", read_data[63:32], mon_e.rd[63:32], mon_e.tag);
            if (mon_e.hk0) chk("const_port0", read_data[31:0], mon_e.k0, mon_e.tag);
            if (mon_e.hk1) chk("const_port1", read_data[63:32], mon_e.k1, mon_e.tag);
        end
    end

    initial begin
        reset = 1'b1; clear_req = 1'b0; write_en = 1'b0; write_addr = '0;
        write_data = '0; write_size = '0; read_addr = '0; read_size = '0;
        m_left = 32; m_drop = 1'b0;
        for (int i = 0; i < 32; i++) m_mem[i] = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        idle_step();
        reset = 1'b0;

        // Write during the clear sequence is dropped; ready rises after 32 cycles.
        wr(5'd3, 32'hAAAA5555, 2'b00);
        for (int i = 0; i < 36; i++) begin
            read_addr = 10'($urandom); read_size = 4'($urandom);
            idle_step();
        end
        rd0(5'd3, 2'b00, 32'h0);
        read_addr[9:5] = 5'd17;

        wr(5'd5, 32'h000000F0, 2'b01);  rd0(5'd5, 2'b00, 32'hFFFFFFF0);
        wr(5'd6, 32'h000000F0, 2'b10);  rd0(5'd6, 2'b00, 32'h000000F0);
        wr(5'd8, 32'h00008001, 2'b11);  rd0(5'd8, 2'b00, 32'hFFFF8001);
        wr(5'd0, 32'hDEADBEEF, 2'b00);  rd0(5'd0, 2'b00, 32'h0);

        // Same-cycle write and read of one entry.
        wr(5'd7, 32'h11111111, 2'b00);
        read_addr[4:0] = 5'd7; read_size[1:0] = 2'b00;
        write_en = 1'b1; write_addr = 5'd7; write_data = 32'h12345678; write_size = 2'b00;
`ifdef REGFILE_BYPASS_EN
        step(1'b1, 32'h12345678, 1'b0, 32'h0);
`else
        step(1'b1, 32'h11111111, 1'b0, 32'h0);
`endif
        write_en = 1'b0;
        rd0(5'd7, 2'b00, 32'h12345678);

        // Two ports on one entry with independent extension.
        wr(5'd9, 32'h00000080, 2'b00);
        read_addr = {5'd9, 5'd9}; read_size = {2'b01, 2'b00};
        step(1'b1, 32'h00000080, 1'b1, 32'hFFFFFF80);

        // Clear request beats a simultaneous write.
        clear_req = 1'b1; write_en = 1'b1; write_addr = 5'd4; write_data = 32'hCAFEF00D;
        idle_step();
        clear_req = 1'b0; write_en = 1'b0;
        for (int i = 0; i < 32; i++) idle_step();
        read_size = '0;
        for (int a = 0; a < 32; a++) rd0(5'(a), 2'b00, 32'h0);

        // Reset in the middle of a clear restarts it.
        wr(5'd12, 32'h5A5A5A5A, 2'b00);
        clear_req = 1'b1; idle_step(); clear_req = 1'b0;
        for (int i = 0; i < 10; i++) idle_step();
        reset = 1'b1; idle_step(); reset = 1'b0;
        for (int i = 0; i < 34; i++) idle_step();
        rd0(5'd12, 2'b00, 32'h0);

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            clear_req  = ($urandom_range(0, 63) == 0);
            write_en   = 1'($urandom);
            write_addr = 5'($urandom);
            write_data = $urandom;
            write_size = 2'($urandom);
            read_addr  = ($urandom_range(0, 3) == 0) ? {write_addr, write_addr} : 10'($urandom);
            read_size  = 4'($urandom);
            idle_step();
        end
        clear_req = 1'b0; write_en = 1'b0;

        @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(sb.size()), 32'h0, tag_cnt);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
